// File: rtl/music_player_pkg.sv
// -----------------------------------------------------------------------------
// music_player_pkg
// Shared definitions for the music player master control unit: the state
// width, the state codes driven onto the debug/LED `state` port, and a
// helper for the width of the flush (clear) counter.
// -----------------------------------------------------------------------------
package music_player_pkg;

  localparam int MCU_STATE_W = 2;

  localparam logic [MCU_STATE_W-1:0] MCU_PAUSED  = 2'd0;
  localparam logic [MCU_STATE_W-1:0] MCU_PLAYING = 2'd1;
  localparam logic [MCU_STATE_W-1:0] MCU_CLEAR   = 2'd2;

  // Counter must be able to hold the value CLEAR_CYCLES.
  function automatic int clear_cnt_width(input int clear_cycles);
    return (clear_cycles < 1) ? 1 : $clog2(clear_cycles + 1);
  endfunction

endpackage : music_player_pkg

// File: rtl/song_index_counter.sv
// -----------------------------------------------------------------------------
// song_index_counter
// Modulo-NUM_SONGS up/down counter holding the current song index.
// Wraps NUM_SONGS-1 -> 0 on inc and 0 -> NUM_SONGS-1 on dec, which also holds
// when NUM_SONGS is smaller than 2**SONG_W.
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-low reset, clears the index to 0
//   inc    in   strobe: advance one song (takes precedence over dec)
//   dec    in   strobe: go back one song
//   song   out  current song index (registered)
// -----------------------------------------------------------------------------
module song_index_counter #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [SONG_W-1:0] song
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) begin
      song <= '0;
    end else if (inc) begin
      song <= (song == LAST_SONG) ? '0 : song + 1'b1;
    end else if (dec) begin
      song <= (song == '0) ? LAST_SONG : song - 1'b1;
    end
  end

endmodule : song_index_counter

// File: rtl/music_player_mcu.sv
// -----------------------------------------------------------------------------
// music_player_mcu
// Master control unit of the music player. Turns one-cycle button pulses into
// the play / reset_player / song controls for song_reader and reacts to the
// end-of-song pulse. Owns song selection, play/pause state and the flush
// (CLEAR) sequence run between songs.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-low reset
//   play_button   in   pulse: toggle play/pause
//   next_button   in   pulse: next song
//   prev_button   in   pulse: previous song
//   autoplay      in   level: continue into the next song at end of song
//   song_done     in   pulse: current song finished
//   play          out  enable to song_reader (high only in PLAYING)
//   reset_player  out  flush of song_reader / note player (high only in CLEAR)
//   song          out  current song index
//   state         out  state code (0 PAUSED, 1 PLAYING, 2 CLEAR)
//
// All outputs come straight from registers; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module music_player_mcu
  import music_player_pkg::*;
#(
  parameter int NUM_SONGS    = 4,
  parameter int SONG_W       = 2,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   play_button,
  input  logic                   next_button,
  input  logic                   prev_button,
  input  logic                   autoplay,
  input  logic                   song_done,
  output logic                   play,
  output logic                   reset_player,
  output logic [SONG_W-1:0]      song,
  output logic [MCU_STATE_W-1:0] state
);

  localparam int CNT_W = clear_cnt_width(CLEAR_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  logic [MCU_STATE_W-1:0] state_q, state_d;
  logic                   resume_q, resume_d;
  logic [CNT_W-1:0]       clr_cnt_q;
  logic                   clear_done;
  logic                   song_inc, song_dec;

  // Last cycle of the flush: the counter has seen CLEAR_CYCLES-1 earlier
  // CLEAR cycles.
  assign clear_done = (clr_cnt_q == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic. The song index only moves on the edge that enters
  // CLEAR, so song_inc/song_dec are raised exactly on those transitions.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    song_inc = 1'b0;
    song_dec = 1'b0;
    case (state_q)
      MCU_PAUSED: begin
        if (next_button) begin
          song_inc = 1'b1;
          state_d  = MCU_CLEAR;
          resume_d = 1'b0;
        end else if (prev_button) begin
          song_dec = 1'b1;
          state_d  = MCU_CLEAR;
          resume_d = 1'b0;
        end else if (play_button) begin
          state_d = MCU_PLAYING;
        end
      end
      MCU_PLAYING: begin
        if (song_done) begin
          // Autoplay stops at the end of the album; the index still wraps.
          song_inc = 1'b1;
          state_d  = MCU_CLEAR;
          resume_d = autoplay && (song != LAST_SONG);
        end else if (next_button) begin
          song_inc = 1'b1;
          state_d  = MCU_CLEAR;
          resume_d = 1'b1;
        end else if (prev_button) begin
          song_dec = 1'b1;
          state_d  = MCU_CLEAR;
          resume_d = 1'b1;
        end else if (play_button) begin
          state_d = MCU_PAUSED;
        end
      end
      MCU_CLEAR: begin
        // Buttons and song_done are dropped while flushing.
        if (clear_done) begin
          state_d = resume_q ? MCU_PLAYING : MCU_PAUSED;
        end
      end
      default: begin
        // Illegal code: flush and come back paused.
        state_d  = MCU_CLEAR;
        resume_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= MCU_CLEAR;
      resume_q  <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      resume_q <= resume_d;
      // Count only inside CLEAR; held at 0 everywhere else so every flush
      // starts from a clean count.
      if (state_q == MCU_CLEAR && !clear_done) begin
        clr_cnt_q <= clr_cnt_q + 1'b1;
      end else begin
        clr_cnt_q <= '0;
      end
    end
  end

  song_index_counter #(
    .NUM_SONGS (NUM_SONGS),
    .SONG_W    (SONG_W)
  ) u_song_index_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (song_inc),
    .dec   (song_dec),
    .song  (song)
  );

  assign play         = (state_q == MCU_PLAYING);
  assign reset_player = (state_q == MCU_CLEAR);
  assign state        = state_q;

endmodule : music_player_mcu
